mac_address_table: RTL and testbench

Parametrised learning/forwarding table for the switch core, replacing the fixed 48-bit block-RAM station table. Sits between the port receive path and the data orchestrator. For each frame header it learns the source MAC against the ingress port and returns an egress port mask for the destination MAC. Optional aging is supported. One request is processed at a time using a sequential scan over a register-based table.

---
 rtl/mac_address_table.sv | 245 ++++++++++++++++++++++++
 tb/tb_mac_address_table.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_address_table.sv
// mac_address_table: learns source MACs per ingress port and returns an egress mask for the destination.
// Optional aging sweep is compiled in with MAC_ADDRESS_TABLE_AGING_EN.
module mac_address_table #(
    parameter int unsigned NUMBER_OF_PORTS     = 2,
    parameter int unsigned TABLE_DEPTH         = 16,
    parameter int unsigned AGING_PERIOD_CYCLES = 50_000_000,
    localparam int unsigned PORT_WIDTH  = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1,
    localparam int unsigned COUNT_WIDTH = $clog2(TABLE_DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       request_valid,
    output logic                       request_ready,
    input  logic [47:0]                request_source_mac,
    input  logic [47:0]                request_destination_mac,
    input  logic [PORT_WIDTH-1:0]      request_port,
    output logic                       response_valid,
    output logic [NUMBER_OF_PORTS-1:0] response_port_mask,
    output logic                       response_hit,
    output logic                       table_full,
    output logic [COUNT_WIDTH-1:0]     table_entry_count
);
    localparam int unsigned INDEX_WIDTH = $clog2(TABLE_DEPTH);
    localparam int unsigned GROUP_BIT   = 40;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_UPDATE  = 3'd2;
    localparam logic [2:0] ST_RESPOND = 3'd3;
`ifdef MAC_ADDRESS_TABLE_AGING_EN
    localparam logic [2:0] ST_AGE     = 3'd4;
    localparam int unsigned PRESCALE_WIDTH =
        (AGING_PERIOD_CYCLES > 1) ? $clog2(AGING_PERIOD_CYCLES) : 1;
`endif

    if (TABLE_DEPTH < 2) begin : g_depth_check
        $error("TABLE_DEPTH must be at least 2");
    end
    if (AGING_PERIOD_CYCLES == 0) begin : g_period_check
        $error("AGING_PERIOD_CYCLES must be nonzero");
    end

    logic [2:0]                 state_q, state_d;
    logic                       ready_d;
    logic                       accept;
    logic                       scan_last;
    logic                       age_request;
    logic                       age_drop;

    logic [INDEX_WIDTH-1:0]     scan_idx_q;
    logic [47:0]                req_src_q, req_dst_q;
    logic [PORT_WIDTH-1:0]      req_port_q;
    logic                       dst_hit_q, src_hit_q, free_found_q;
    logic [PORT_WIDTH-1:0]      dst_port_q;
    logic [INDEX_WIDTH-1:0]     src_idx_q, free_idx_q;

    logic                       entry_valid_q [TABLE_DEPTH];
    logic [47:0]                entry_mac_q   [TABLE_DEPTH];
    logic [PORT_WIDTH-1:0]      entry_port_q  [TABLE_DEPTH];

    logic                       port_ok;
    logic                       learn_en, learn_new;
    logic [INDEX_WIDTH-1:0]     learn_idx;
    logic [COUNT_WIDTH-1:0]     count_d;
    logic [NUMBER_OF_PORTS-1:0] ingress_bit, resp_mask_d;
    logic                       resp_hit_d;

    assign scan_last = (scan_idx_q == INDEX_WIDTH'(TABLE_DEPTH - 1));
    assign port_ok   = (32'(req_port_q) < NUMBER_OF_PORTS);

`ifdef MAC_ADDRESS_TABLE_AGING_EN
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      tick_now, tick_soon;
    logic                      tick_pending_q, tick_pending_d;
    logic [1:0]                entry_age_q [TABLE_DEPTH];

    // tick_soon lets ready drop a cycle early so a tick always wins over a new request
    assign tick_now       = (prescale_q == PRESCALE_WIDTH'(AGING_PERIOD_CYCLES - 1));
    assign prescale_d     = tick_now ? '0 : PRESCALE_WIDTH'(prescale_q + 1'b1);
    assign tick_soon      = (prescale_d == PRESCALE_WIDTH'(AGING_PERIOD_CYCLES - 1));
    assign tick_pending_d = tick_now | (tick_pending_q & ~((state_q == ST_AGE) & scan_last));
    assign age_request    = tick_pending_q | tick_now;
    assign age_drop       = (state_q == ST_AGE) && entry_valid_q[scan_idx_q]
                            && (entry_age_q[scan_idx_q] == 2'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q     <= '0;
            tick_pending_q <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            tick_pending_q <= tick_pending_d;
        end
    end
`else
    assign age_request = 1'b0;
    assign age_drop    = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (age_request) begin
`ifdef MAC_ADDRESS_TABLE_AGING_EN
                    state_d = ST_AGE;
`endif
                end else if (request_valid && request_ready) begin
                    accept  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN:    if (scan_last) state_d = ST_UPDATE;
            ST_UPDATE:  state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
`ifdef MAC_ADDRESS_TABLE_AGING_EN
            ST_AGE:     if (scan_last) state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
`ifdef MAC_ADDRESS_TABLE_AGING_EN
        ready_d = (state_d == ST_IDLE) && !tick_pending_d && !tick_soon;
`else
        ready_d = (state_d == ST_IDLE);
`endif
    end

    // Learn decision and forwarding result, both from the pre-learn scan results
    always_comb begin
        learn_en    = (state_q == ST_UPDATE) && port_ok && !req_src_q[GROUP_BIT]
                      && (src_hit_q || free_found_q);
        learn_new   = learn_en && !src_hit_q;
        learn_idx   = src_hit_q ? src_idx_q : free_idx_q;
        count_d     = COUNT_WIDTH'(table_entry_count + COUNT_WIDTH'(learn_new)
                                   - COUNT_WIDTH'(age_drop));
        ingress_bit = port_ok ? (NUMBER_OF_PORTS'(1) << req_port_q) : '0;
        resp_mask_d = ~ingress_bit;
        resp_hit_d  = 1'b0;
        if (!req_dst_q[GROUP_BIT] && dst_hit_q) begin
            resp_hit_d  = 1'b1;
            resp_mask_d = (port_ok && dst_port_q == req_port_q) ? '0
                        : (NUMBER_OF_PORTS'(1) << dst_port_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            request_ready <= 1'b1;
        end else begin
            state_q       <= state_d;
            request_ready <= ready_d;
        end
    end

    // Datapath: capture, scan, learn, response and aging sweep
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx_q         <= '0;
            req_src_q          <= '0;
            req_dst_q          <= '0;
            req_port_q         <= '0;
            dst_hit_q          <= 1'b0;
            dst_port_q         <= '0;
            src_hit_q          <= 1'b0;
            src_idx_q          <= '0;
            free_found_q       <= 1'b0;
            free_idx_q         <= '0;
            response_valid     <= 1'b0;
            response_port_mask <= '0;
            response_hit       <= 1'b0;
            table_full         <= 1'b0;
            table_entry_count  <= '0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                entry_valid_q[i] <= 1'b0;
                entry_mac_q[i]   <= '0;
                entry_port_q[i]  <= '0;
`ifdef MAC_ADDRESS_TABLE_AGING_EN
                entry_age_q[i]   <= '0;
`endif
            end
        end else begin
            response_valid    <= 1'b0;
            table_entry_count <= count_d;
            table_full        <= (count_d == COUNT_WIDTH'(TABLE_DEPTH));
            case (state_q)
                ST_IDLE: begin
                    scan_idx_q   <= '0;
                    dst_hit_q    <= 1'b0;
                    src_hit_q    <= 1'b0;
                    free_found_q <= 1'b0;
                    if (accept) begin
                        req_src_q  <= request_source_mac;
                        req_dst_q  <= request_destination_mac;
                        req_port_q <= request_port;
                    end
                end
                ST_SCAN: begin
                    if (entry_valid_q[scan_idx_q]) begin
                        if (!dst_hit_q && entry_mac_q[scan_idx_q] == req_dst_q) begin
                            dst_hit_q  <= 1'b1;
                            dst_port_q <= entry_port_q[scan_idx_q];
                        end
                        if (entry_mac_q[scan_idx_q] == req_src_q) begin
                            src_hit_q <= 1'b1;
                            src_idx_q <= scan_idx_q;
                        end
                    end else if (!free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= scan_idx_q;
                    end
                    scan_idx_q <= INDEX_WIDTH'(scan_idx_q + 1'b1);
                end
                ST_UPDATE: begin
                    if (learn_en) begin
                        entry_valid_q[learn_idx] <= 1'b1;
                        entry_mac_q[learn_idx]   <= req_src_q;
                        entry_port_q[learn_idx]  <= req_port_q;
`ifdef MAC_ADDRESS_TABLE_AGING_EN
                        entry_age_q[learn_idx]   <= 2'd0;
`endif
                    end
                    response_valid     <= 1'b1;
                    response_port_mask <= resp_mask_d;
                    response_hit       <= resp_hit_d;
                end
`ifdef MAC_ADDRESS_TABLE_AGING_EN
                ST_AGE: begin
                    if (entry_valid_q[scan_idx_q]) begin
                        if (entry_age_q[scan_idx_q] == 2'd3) begin
                            entry_valid_q[scan_idx_q] <= 1'b0;
                        end else begin
                            entry_age_q[scan_idx_q] <= 2'(entry_age_q[scan_idx_q] + 2'd1);
                        end
                    end
                    scan_idx_q <= INDEX_WIDTH'(scan_idx_q + 1'b1);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_address_table.sv
// Self-checking bench for mac_address_table: vector table driven through a scoreboard,
// plus latency, mid-scan reset and (when compiled in) aging sequences.
module tb_mac_address_table;
    localparam int unsigned N  = 2;
    localparam int unsigned D  = 16;
    localparam int unsigned P  = 100;
    localparam int unsigned PW = 1;
    localparam int unsigned CW = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          request_valid;
    logic          request_ready;
    logic [47:0]   request_source_mac;
    logic [47:0]   request_destination_mac;
    logic [PW-1:0] request_port;
    logic          response_valid;
    logic [N-1:0]  response_port_mask;
    logic          response_hit;
    logic          table_full;
    logic [CW-1:0] table_entry_count;

    always #5 clock = ~clock;

    mac_address_table #(
        .NUMBER_OF_PORTS(N), .TABLE_DEPTH(D), .AGING_PERIOD_CYCLES(P)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .request_valid(request_valid), .request_ready(request_ready),
        .request_source_mac(request_source_mac),
        .request_destination_mac(request_destination_mac),
        .request_port(request_port),
        .response_valid(response_valid), .response_port_mask(response_port_mask),
        .response_hit(response_hit), .table_full(table_full),
        .table_entry_count(table_entry_count)
    );

    typedef struct {
        logic [PW-1:0] port;
        logic [47:0]   src;
        logic [47:0]   dst;
        logic [N-1:0]  mask;
        logic          hit;
        int unsigned   count;
        logic          full;
    } vec_t;

    typedef struct {
        logic [N-1:0] mask;
        logic         hit;
        int unsigned  count;
        logic         full;
    } exp_t;

    localparam logic [47:0] MAC_A     = 48'h00_00_00_00_00_0A;
    localparam logic [47:0] MAC_B     = 48'h00_00_00_00_00_0B;
    localparam logic [47:0] MAC_C     = 48'h00_00_00_00_00_0C;
    localparam logic [47:0] MAC_D     = 48'h00_00_00_00_00_0D;
    localparam logic [47:0] MAC_E     = 48'h00_00_00_00_00_0E;
    localparam logic [47:0] MAC_F     = 48'h00_00_00_00_00_0F;
    localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MAC_MCAST = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] MAC_UNK   = 48'h00_00_00_00_09_99;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [PW-1:0] port, input logic [47:0] src,
                                input logic [47:0] dst, input logic [N-1:0] mask,
                                input logic hit, input int unsigned count, input logic full);
        vec_t v;
        v.port = port; v.src = src; v.dst = dst;
        v.mask = mask; v.hit = hit; v.count = count; v.full = full;
        vecs.push_back(v);
    endfunction

    // Scoreboard consumer: every response pulse pops one expected record
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && response_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_response", 64'(response_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("mask",  64'(response_port_mask), 64'(e.mask));
                check("hit",   64'(response_hit),       64'(e.hit));
                check("count", 64'(table_entry_count),  64'(e.count));
                check("full",  64'(table_full),         64'(e.full));
            end
        end
    end

    task automatic send(input vec_t v);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clock);
        request_valid           = 1'b1;
        request_port            = v.port;
        request_source_mac      = v.src;
        request_destination_mac = v.dst;
        n = 0;
        while (!request_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!request_ready) begin
            check("accept_timeout", 64'(request_ready), 64'(1));
            request_valid = 1'b0;
            return;
        end
        @(posedge clock);
        e.mask = v.mask; e.hit = v.hit; e.count = v.count; e.full = v.full;
        sb.push_back(e);
        #1 request_valid = 1'b0;
        request_source_mac      = '0;
        request_destination_mac = '0;
        got = 1'b0;
        for (int c = 1; c <= int'(D) + 10 && !got; c++) begin
            @(negedge clock);
            if (response_valid) begin
                got = 1'b1;
                check("latency", 64'(c), 64'(D + 2));
                check("ready_during_response", 64'(request_ready), 64'(0));
            end
        end
        if (!got) check("response_timeout", 64'(got), 64'(1));
`ifndef MAC_ADDRESS_TABLE_AGING_EN
        @(negedge clock);
        check("ready_after_response", 64'(request_ready), 64'(1));
`endif
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        bit   seen;
        reset_n                 = 1'b0;
        request_valid           = 1'b0;
        request_port            = '0;
        request_source_mac      = '0;
        request_destination_mac = '0;

        // Basic learn / forward / filter / flood cases
        add(1'b0, MAC_A,     MAC_B,     2'b10, 1'b0, 1, 1'b0);
        add(1'b1, MAC_B,     MAC_A,     2'b01, 1'b1, 2, 1'b0);
        add(1'b0, MAC_A,     MAC_A,     2'b00, 1'b1, 2, 1'b0);
        add(1'b1, MAC_B,     MAC_BCAST, 2'b01, 1'b0, 2, 1'b0);
        add(1'b0, MAC_MCAST, MAC_B,     2'b10, 1'b1, 2, 1'b0);
        add(1'b1, MAC_C,     MAC_MCAST, 2'b01, 1'b0, 3, 1'b0);
        add(1'b1, MAC_A,     MAC_C,     2'b00, 1'b1, 3, 1'b0);
        add(1'b0, MAC_D,     MAC_A,     2'b10, 1'b1, 4, 1'b0);
        add(1'b0, MAC_E,     MAC_E,     2'b10, 1'b0, 5, 1'b0);
        add(1'b1, MAC_F,     MAC_E,     2'b01, 1'b1, 6, 1'b0);
        // Fill to capacity, then overflow and re-learn with a full table
        for (int i = 0; i < 10; i++)
            add(1'b0, 48'h100 + 48'(i), MAC_UNK, 2'b10, 1'b0, 7 + i, (7 + i) == 16);
        add(1'b1, 48'h200, MAC_UNK, 2'b01, 1'b0, 16, 1'b1);
        add(1'b0, 48'h100, 48'h200, 2'b10, 1'b0, 16, 1'b1);
        add(1'b1, 48'h100, MAC_A,   2'b00, 1'b1, 16, 1'b1);
        add(1'b0, MAC_A,   48'h100, 2'b10, 1'b1, 16, 1'b1);

        repeat (3) @(negedge clock);
        check("reset_ready",  64'(request_ready),      64'(1));
        check("reset_valid",  64'(response_valid),     64'(0));
        check("reset_hit",    64'(response_hit),       64'(0));
        check("reset_mask",   64'(response_port_mask), 64'(0));
        check("reset_full",   64'(table_full),         64'(0));
        check("reset_count",  64'(table_entry_count),  64'(0));
        reset_n = 1'b1;

        foreach (vecs[i]) send(vecs[i]);

        // Reset during the scan aborts the request with no response
        @(negedge clock);
        request_valid           = 1'b1;
        request_port            = 1'b0;
        request_source_mac      = 48'h300;
        request_destination_mac = MAC_A;
        @(posedge clock);
        #1 request_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midscan_count_in_reset", 64'(table_entry_count), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);
        check("midscan_ready_after", 64'(request_ready),     64'(1));
        check("midscan_count_after", 64'(table_entry_count), 64'(0));
        check("midscan_full_after",  64'(table_full),        64'(0));
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (response_valid) seen = 1'b1;
        end
        check("midscan_no_response", 64'(seen), 64'(0));
        // Table is empty again: former entries flood
        v.port = 1'b0; v.src = MAC_D; v.dst = MAC_A;
        v.mask = 2'b10; v.hit = 1'b0; v.count = 1; v.full = 1'b0;
        send(v);

`ifdef MAC_ADDRESS_TABLE_AGING_EN
        apply_reset();
        v.port = 1'b0; v.src = MAC_A; v.dst = MAC_B;
        v.mask = 2'b10; v.hit = 1'b0; v.count = 1; v.full = 1'b0;
        send(v);
        repeat (450) @(negedge clock);
        check("aged_out_count", 64'(table_entry_count), 64'(0));
        v.port = 1'b1; v.src = MAC_MCAST; v.dst = MAC_A;
        v.mask = 2'b01; v.hit = 1'b0; v.count = 0;
        send(v);
        v.port = 1'b0; v.src = MAC_A; v.dst = MAC_B;
        v.mask = 2'b10; v.hit = 1'b0; v.count = 1;
        send(v);
        for (int k = 0; k < 7; k++) begin
            repeat (55) @(negedge clock);
            send(v);
        end
        v.port = 1'b1; v.src = MAC_MCAST; v.dst = MAC_A;
        v.mask = 2'b01; v.hit = 1'b1; v.count = 1;
        send(v);
`endif

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
